// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory initiator: access-size
// encodings, FSM state type, default widths and the alignment rule.
package lsu_pkg;

    localparam int ADDR_W_DEF      = 13;
    localparam int WORD_ADDR_W_DEF = 10;
    localparam int DATA_W_DEF      = 64;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ERR      = 3'd1,
        RD       = 3'd2,
        RD_WAIT  = 3'd3,
        MERGE_WR = 3'd4,
        WR       = 3'd5,
        RESP     = 3'd6
    } lsu_state_t;

    // Natural alignment: the byte offset must be a multiple of the access size.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (off[0] == 1'b0);
            SZ_W:    ok = (off[1:0] == 2'b00);
            SZ_D:    ok = (off == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper: extracts and sign/zero-extends load data from a 64-bit
// word, and merges the low bytes of store data into a word for
// read-modify-write. Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [2:0]        offset_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] load_o,
    output logic [DATA_W-1:0] merged_o
);

    logic [5:0]        shamt_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DATA_W-1:0] mask_s;
    logic [DATA_W-1:0] lane_mask_s;

    // Shift the addressed lanes to bit 0, extend per size, and build the store merge.
    always_comb begin
        shamt_s   = {offset_i, 3'b000};
        shifted_s = word_i >> shamt_s;
        mask_s    = {DATA_W{1'b1}};
        load_o    = shifted_s;
        case (size_i)
            SZ_B: begin
                mask_s = 64'h0000_0000_0000_00FF;
                if (unsigned_i) begin
                    load_o = {56'd0, shifted_s[7:0]};
                end else begin
                    load_o = {{56{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SZ_H: begin
                mask_s = 64'h0000_0000_0000_FFFF;
                if (unsigned_i) begin
                    load_o = {48'd0, shifted_s[15:0]};
                end else begin
                    load_o = {{48{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            SZ_W: begin
                mask_s = 64'h0000_0000_FFFF_FFFF;
                if (unsigned_i) begin
                    load_o = {32'd0, shifted_s[31:0]};
                end else begin
                    load_o = {{32{shifted_s[31]}}, shifted_s[31:0]};
                end
            end
            default: begin
                mask_s = {DATA_W{1'b1}};
                load_o = shifted_s;
            end
        endcase
        lane_mask_s = mask_s << shamt_s;
        merged_o    = (word_i & ~lane_mask_s) | ((wdata_i & mask_s) << shamt_s);
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the execute stage and DATA_MEMORY.
// Turns byte-addressed B/H/W/D accesses into 64-bit word accesses, using
// read-modify-write for partial stores. Optional per-class counters are
// built when LSU_STATS_EN is defined.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WORD_ADDR_W = WORD_ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_err,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [WORD_ADDR_W-1:0] mem_rd_addr,
    output logic [WORD_ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
`ifdef LSU_STATS_EN
    ,
    output logic [31:0]            stat_loads,
    output logic [31:0]            stat_stores,
    output logic [31:0]            stat_errs
`endif
);

    lsu_state_t state_q, state_d;

    logic                   we_q, we_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;

    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [WORD_ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic [WORD_ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_err_q, resp_err_d;
    logic [DATA_W-1:0]      resp_rdata_q, resp_rdata_d;

    logic [DATA_W-1:0]      load_data_s;
    logic [DATA_W-1:0]      merged_s;

    // The word arriving during RD_WAIT is both the load source and the RMW base.
    lsu_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .word_i    (mem_rdata),
        .offset_i  (addr_q[2:0]),
        .size_i    (size_q),
        .unsigned_i(uns_q),
        .wdata_i   (wdata_q),
        .load_o    (load_data_s),
        .merged_o  (merged_s)
    );

    assign req_ready   = rst && (state_q == IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wdata   = mem_wdata_q;

    // Next state, request latching, and registered outputs derived from the next state.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        uns_d         = uns_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mem_rd_addr_d = mem_rd_addr_q;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wdata_d   = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (!is_aligned(req_size, req_addr[2:0])) begin
                        state_d = ERR;
                    end else if (req_we && (req_size == SZ_D)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ERR:      state_d = IDLE;
            RD:       state_d = RD_WAIT;
            RD_WAIT: begin
                if (we_q) begin
                    state_d = MERGE_WR;
                end else begin
                    state_d = RESP;
                end
            end
            MERGE_WR: state_d = RESP;
            WR:       state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        mem_read_d   = (state_d == RD);
        mem_write_d  = (state_d == WR) || (state_d == MERGE_WR);
        resp_valid_d = (state_d == RESP) || (state_d == ERR);
        resp_err_d   = (state_d == ERR);

        if (state_d == RD) begin
            mem_rd_addr_d = addr_d[ADDR_W-1:3];
        end else begin
            mem_rd_addr_d = mem_rd_addr_q;
        end

        if (state_d == WR) begin
            mem_wr_addr_d = addr_d[ADDR_W-1:3];
            mem_wdata_d   = wdata_d;
        end else if (state_d == MERGE_WR) begin
            mem_wr_addr_d = addr_q[ADDR_W-1:3];
            mem_wdata_d   = merged_s;
        end else begin
            mem_wr_addr_d = mem_wr_addr_q;
            mem_wdata_d   = mem_wdata_q;
        end

        if ((state_d == RESP) && (state_q == RD_WAIT) && !we_q) begin
            resp_rdata_d = load_data_s;
        end else begin
            resp_rdata_d = {DATA_W{1'b0}};
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
            addr_q        <= {ADDR_W{1'b0}};
            wdata_q       <= {DATA_W{1'b0}};
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_rd_addr_q <= {WORD_ADDR_W{1'b0}};
            mem_wr_addr_q <= {WORD_ADDR_W{1'b0}};
            mem_wdata_q   <= {DATA_W{1'b0}};
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

`ifdef LSU_STATS_EN
    logic [31:0] stat_loads_q, stat_stores_q, stat_errs_q;

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;

    // Saturating per-class counters, bumped on the response cycle of each access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_loads_q  <= 32'd0;
            stat_stores_q <= 32'd0;
            stat_errs_q   <= 32'd0;
        end else begin
            if ((state_q == RESP) && !we_q && (stat_loads_q != 32'hFFFF_FFFF)) begin
                stat_loads_q <= stat_loads_q + 32'd1;
            end else begin
                stat_loads_q <= stat_loads_q;
            end
            if ((state_q == RESP) && we_q && (stat_stores_q != 32'hFFFF_FFFF)) begin
                stat_stores_q <= stat_stores_q + 32'd1;
            end else begin
                stat_stores_q <= stat_stores_q;
            end
            if ((state_q == ERR) && (stat_errs_q != 32'hFFFF_FFFF)) begin
                stat_errs_q <= stat_errs_q + 32'd1;
            end else begin
                stat_errs_q <= stat_errs_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed scenarios followed by
// random mixed traffic compared against a byte-array reference memory.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [12:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [9:0]  mem_rd_addr, mem_wr_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;
`ifdef LSU_STATS_EN
    logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

    always #5 clk = ~clk;

    lsu_mem_initiator dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rd_addr (mem_rd_addr),
        .mem_wr_addr (mem_wr_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef LSU_STATS_EN
        ,
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errs   (stat_errs)
`endif
    );

    // DATA_MEMORY stand-in: synchronous write, registered read.
    logic [63:0] dmem [0:1023];
    int wr_total = 0;
    int both_hi  = 0;
    always @(posedge clk) begin
        if (mem_write) begin
            dmem[mem_wr_addr] <= mem_wdata;
            wr_total <= wr_total + 1;
        end
        if (mem_read) mem_rdata <= dmem[mem_rd_addr];
        if (mem_read && mem_write) both_hi <= both_hi + 1;
    end

    // Reference memory as individual bytes.
    logic [7:0] rb [0:8191];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_loads = 0, exp_stores = 0, exp_errs = 0;

    // Per-transaction observations.
    logic [63:0] o_rd, o_wdat;
    logic        o_err;
    logic [9:0]  o_wa;
    int          o_lat, o_wcyc, o_nrd, o_nwr;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_aligned(input logic [1:0] sz, input logic [12:0] a);
        return (int'(a) % (1 << sz)) == 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [1:0] sz, input logic uns, input logic [12:0] a);
        logic [63:0] v;
        int nb;
        v  = 64'd0;
        nb = 1 << sz;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rb[int'(a) + i];
        if (!uns && nb < 8 && v[8*nb-1]) begin
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [12:0] a, input logic [63:0] wd);
        for (int i = 0; i < (1 << sz); i++) rb[int'(a) + i] = wd[8*i +: 8];
    endtask

    // Issue one request and watch the DUT for up to 20 cycles after acceptance.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [12:0] a, input logic [63:0] wd);
        int g;
        g = 0;
        o_rd = 64'd0; o_err = 1'b0; o_lat = 0; o_wcyc = 0; o_wa = 10'd0;
        o_wdat = 64'd0; o_nrd = 0; o_nwr = 0;
        @(negedge clk);
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_read) o_nrd++;
            if (mem_write) begin
                o_nwr++;
                o_wcyc = c;
                o_wa   = mem_wr_addr;
                o_wdat = mem_wdata;
            end
            if (resp_valid) begin
                o_lat = c;
                o_rd  = resp_rdata;
                o_err = resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Full transaction: issue, compare against the reference, update reference.
    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [12:0] a, input logic [63:0] wd);
        logic        e_err;
        logic [63:0] e_rd;
        int          e_lat;
        e_err = !ref_aligned(sz, a);
        if (e_err || we) e_rd = 64'd0;
        else             e_rd = ref_load(sz, uns, a);
        if (e_err)           e_lat = 1;
        else if (!we)        e_lat = 3;
        else if (sz == 2'd3) e_lat = 2;
        else                 e_lat = 4;
        do_req(we, sz, uns, a, wd);
        check64("latency", 64'(o_lat), 64'(e_lat));
        check64("resp_err", {63'd0, o_err}, {63'd0, e_err});
        check64("resp_rdata", o_rd, e_rd);
        if (e_err) begin
            check64("err_strobes", 64'(o_nrd + o_nwr), 64'd0);
            exp_errs++;
        end else if (we) begin
            check64("store_writes", 64'(o_nwr), 64'd1);
            check64("store_wr_addr", {54'd0, o_wa}, {54'd0, a[12:3]});
            ref_store(sz, a, wd);
            exp_stores++;
        end else begin
            check64("load_writes", 64'(o_nwr), 64'd0);
            exp_loads++;
        end
    endtask

    initial begin
        int          seen_resp, wr_before;
        logic        r_we, r_uns;
        logic [1:0]  r_sz;
        logic [12:0] r_a;
        logic [63:0] r_wd, w;

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 13'd0; req_wdata = 64'd0;
        for (int i = 0; i < 1024; i++) dmem[i] = 64'd0;
        for (int i = 0; i < 8192; i++) rb[i] = 8'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check64("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check64("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
        check64("rst_addrs", {44'd0, mem_rd_addr, mem_wr_addr}, 64'd0);
        check64("rst_wdata", mem_wdata, 64'd0);
        check64("rst_resp", {62'd0, resp_valid, resp_err}, 64'd0);
        check64("rst_rdata", resp_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check64("ready_after_rst", {63'd0, req_ready}, 64'd1);

        // Full doubleword store
        txn(1'b1, 2'd3, 1'b0, 13'h040, 64'h0123456789ABCDEF);
        check64("sd_wr_cycle", 64'(o_wcyc), 64'd1);
        check64("sd_wr_addr", {54'd0, o_wa}, 64'd8);
        check64("sd_wr_data", o_wdat, 64'h0123456789ABCDEF);
        check64("sd_no_read", 64'(o_nrd), 64'd0);

        // Byte loads, signed and unsigned
        txn(1'b1, 2'd3, 1'b0, 13'h040, 64'h80FFFFFFFFFFFFFF);
        txn(1'b0, 2'd0, 1'b0, 13'h047, 64'd0);
        check64("lb_value", o_rd, 64'hFFFFFFFFFFFFFF80);
        txn(1'b0, 2'd0, 1'b1, 13'h047, 64'd0);
        check64("lbu_value", o_rd, 64'h0000000000000080);

        // Halfword read-modify-write
        txn(1'b1, 2'd3, 1'b0, 13'h040, 64'h1111111111111111);
        txn(1'b1, 2'd1, 1'b0, 13'h042, 64'h000000000000BEEF);
        check64("sh_reads", 64'(o_nrd), 64'd1);
        check64("sh_wr_data", o_wdat, 64'h11111111BEEF1111);
        txn(1'b0, 2'd3, 1'b0, 13'h040, 64'd0);
        check64("ld_after_sh", o_rd, 64'h11111111BEEF1111);

        // Misaligned word load
        txn(1'b0, 2'd2, 1'b0, 13'h006, 64'd0);
        check64("lw_mis_err", {63'd0, o_err}, 64'd1);
        check64("lw_mis_rdata", o_rd, 64'd0);

        // Reset in the middle of a read-modify-write
        txn(1'b1, 2'd3, 1'b0, 13'h040, 64'h1111111111111111);
        seen_resp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 13'h042; req_wdata = 64'h0000000000002222;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wr_before = wr_total;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen_resp++;
        end
        check64("abort_no_resp", 64'(seen_resp), 64'd0);
        check64("abort_no_write", 64'(wr_total), 64'(wr_before));
        check64("ready_in_rst", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check64("ready_after_abort", {63'd0, req_ready}, 64'd1);
        txn(1'b0, 2'd3, 1'b0, 13'h040, 64'd0);
        check64("word_unchanged", o_rd, 64'h1111111111111111);

        // Random mixed traffic
        for (int n = 0; n < 1000; n++) begin
            r_we  = 1'($urandom_range(0, 1));
            r_sz  = 2'($urandom_range(0, 3));
            r_uns = 1'($urandom_range(0, 1));
            r_a   = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 7) != 0) r_a = 13'(int'(r_a) & ~((1 << r_sz) - 1));
            r_wd  = {$urandom, $urandom};
            txn(r_we, r_sz, r_uns, r_a, r_wd);
        end

        // Final memory image against the reference
        repeat (2) @(posedge clk);
        for (int wi = 0; wi < 1024; wi++) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = rb[wi*8 + i];
            check64("mem_image", dmem[wi], w);
        end
        check64("strobe_overlap", 64'(both_hi), 64'd0);
`ifdef LSU_STATS_EN
        check64("stat_loads", {32'd0, stat_loads}, 64'(exp_loads));
        check64("stat_stores", {32'd0, stat_stores}, 64'(exp_stores));
        check64("stat_errs", {32'd0, stat_errs}, 64'(exp_errs));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
